// File: rtl/platform_pkg.sv
`default_nettype none
// ============================================================================
// platform_pkg
// ----------------------------------------------------------------------------
// Shared constants and types for the platform line reader: display geometry,
// platform-RAM word width, address width and the prefetch FSM state encoding.
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
package platform_pkg;

  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_LINE = H_ACTIVE / WORD_W;
  localparam int ADDR_W         = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage : platform_pkg
`default_nettype wire

// File: rtl/platform_line_bank.sv
`default_nettype none
// ============================================================================
// platform_line_bank
// ----------------------------------------------------------------------------
// Two line banks of H_ACTIVE bits. One word-wide write port fills a bank,
// a whole-bank clear wipes a bank in one cycle, and a single-bit combinational
// read port serves pixel lookups.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset (clears both)
//   wr_en/wr_bank       word write enable and target bank
//   wr_word/wr_data     word index within the line and its data
//   clr_en/clr_bank     one-cycle clear of a whole bank
//   rd_bank/rd_col      bank and column for the bit read
//   rd_bit              bit at rd_col of rd_bank
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module platform_line_bank #(
  parameter int H_ACTIVE = 640,
  parameter int WORD_W   = 16,
  parameter int WIDX_W   = 6,
  parameter int COL_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [WIDX_W-1:0] wr_word,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic              clr_bank,
  input  logic              rd_bank,
  input  logic [COL_W-1:0]  rd_col,
  output logic              rd_bit
);

  localparam int WPL = H_ACTIVE / WORD_W;

  logic [1:0][H_ACTIVE-1:0] bank_q;
  logic [1:0][H_ACTIVE-1:0] bank_d;

  always_comb begin
    bank_d = bank_q;
    if (clr_en) begin
      bank_d[clr_bank] = '0;
    end
    if (wr_en) begin
      for (int w = 0; w < WPL; w++) begin
        if (wr_word == WIDX_W'(w)) begin
          bank_d[wr_bank][w*WORD_W +: WORD_W] = wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign rd_bit = bank_q[rd_bank][rd_col];

endmodule : platform_line_bank
`default_nettype wire

// File: rtl/platform_reader.sv
`default_nettype none
// ============================================================================
// platform_reader
// ----------------------------------------------------------------------------
// Double-buffered platform line reader. On each line_start the banks swap and
// the next row is prefetched from platform RAM into the back bank, while the
// front bank answers per-pixel lookups with horizontal scroll.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   line_start            hblank pulse: swap banks, start prefetch
//   next_y, camera_pos    row to prefetch and scroll, sampled on line_start
//   pixel_req, x          lookup request for screen column x
//   mem_rd, mem_addr      platform-RAM read strobe and word address
//   mem_rdata             read data, valid one cycle after mem_rd
//   platform_pixel        looked-up bit (0 when no request)
//   pixel_valid           pixel_req delayed by one cycle
//   fetch_busy            prefetch in progress (FETCH or DRAIN)
//   underrun              pulse when line_start cut a prefetch short
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module platform_reader #(
  parameter int H_ACTIVE = platform_pkg::H_ACTIVE,
  parameter int V_ACTIVE = platform_pkg::V_ACTIVE,
  parameter int WORD_W   = platform_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [8:0]        next_y,
  input  logic [9:0]        camera_pos,
  input  logic              pixel_req,
  input  logic [9:0]        x,
  output logic              mem_rd,
  output logic [14:0]       mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              platform_pixel,
  output logic              pixel_valid,
  output logic              fetch_busy,
  output logic              underrun
);

  import platform_pkg::*;

  localparam int                WPL        = H_ACTIVE / WORD_W;
  localparam int                WIDX_W     = $clog2(WPL);
  localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(WPL - 1);
  localparam logic [10:0]       H_ACTIVE_W = 11'(H_ACTIVE);

  fetch_state_t      state_q, state_d;
  logic [WIDX_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [WIDX_W-1:0] rd_word_q, rd_word_d;
  logic              bank_sel_q, bank_sel_d;
  logic [9:0]        scroll_q, scroll_d;
  logic              pix_q, pix_d;
  logic              valid_q, valid_d;
  logic              underrun_q, underrun_d;

  logic              in_range;
  logic              clr_en;
  logic              rd_bit;
  logic [10:0]       col_sum;
  logic [9:0]        lookup_col;
  logic [ADDR_W-1:0] row_base;

  assign in_range   = (next_y < 9'(V_ACTIVE));
  assign row_base   = ADDR_W'(next_y) * ADDR_W'(WPL);

  assign mem_rd     = (state_q == ST_FETCH);
  assign mem_addr   = addr_q;
  assign fetch_busy = (state_q == ST_FETCH) || (state_q == ST_DRAIN);

  // Scroll is below H_ACTIVE, so one conditional subtract wraps the sum.
  assign col_sum    = {1'b0, x} + {1'b0, scroll_q};
  assign lookup_col = (col_sum >= H_ACTIVE_W) ? 10'(col_sum - H_ACTIVE_W)
                                              : col_sum[9:0];

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    addr_d     = addr_q;
    bank_sel_d = bank_sel_q;
    scroll_d   = scroll_q;
    clr_en     = 1'b0;
    underrun_d = 1'b0;
    // A read issued in the line_start cycle belongs to the aborted prefetch,
    // so its returning data is dropped.
    rd_pend_d  = mem_rd && !line_start;
    rd_word_d  = word_q;

    if (line_start) begin
      underrun_d = fetch_busy;
      bank_sel_d = ~bank_sel_q;
      scroll_d   = (camera_pos >= 10'(H_ACTIVE)) ? camera_pos - 10'(H_ACTIVE)
                                                 : camera_pos;
      word_d     = '0;
      if (in_range) begin
        state_d = ST_FETCH;
        addr_d  = row_base;
      end else begin
        // Wipe the bank that becomes back (the current front).
        state_d = ST_DONE;
        clr_en  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (word_q == LAST_WORD) begin
            state_d = ST_DRAIN;
          end else begin
            word_d = word_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end
        end
        // The last word's data is written at the end of this cycle.
        ST_DRAIN: state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end

    pix_d   = pixel_req & rd_bit;
    valid_d = pixel_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      addr_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_word_q  <= '0;
      bank_sel_q <= 1'b0;
      scroll_q   <= '0;
      pix_q      <= 1'b0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      rd_pend_q  <= rd_pend_d;
      rd_word_q  <= rd_word_d;
      bank_sel_q <= bank_sel_d;
      scroll_q   <= scroll_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign platform_pixel = pix_q;
  assign pixel_valid    = valid_q;
  assign underrun       = underrun_q;

  // Front bank is bank_sel_q; returned words go to the other one. A write
  // landing on a swap edge still completes into the bank being swapped out.
  platform_line_bank #(
    .H_ACTIVE (H_ACTIVE),
    .WORD_W   (WORD_W),
    .WIDX_W   (WIDX_W),
    .COL_W    (10)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (rd_pend_q),
    .wr_bank  (~bank_sel_q),
    .wr_word  (rd_word_q),
    .wr_data  (mem_rdata),
    .clr_en   (clr_en),
    .clr_bank (bank_sel_q),
    .rd_bank  (bank_sel_q),
    .rd_col   (lookup_col),
    .rd_bit   (rd_bit)
  );

endmodule : platform_reader
`default_nettype wire

// File: tb/tb_platform_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_platform_reader
// ----------------------------------------------------------------------------
// Directed self-checking bench for platform_reader with a behavioural
// platform RAM (row 150: words 3..10 all ones; row 151: all ones).
// ----------------------------------------------------------------------------
// Revision: 1.0 - initial release
// ============================================================================
module tb_platform_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [8:0]  next_y = '0;
  logic [9:0]  camera_pos = '0;
  logic        pixel_req = 1'b0;
  logic [9:0]  x = '0;
  logic        mem_rd;
  logic [14:0] mem_addr;
  logic [15:0] mem_rdata = 16'hA5A5;
  logic        platform_pixel;
  logic        pixel_valid;
  logic        fetch_busy;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  logic [15:0] ram [0:32767];

  int          rd_cnt = 0;
  logic [14:0] rd_first = '0;
  logic [14:0] rd_last = '0;
  int          seq_err = 0;
  logic        busy_seen = 1'b0;
  int          ur_cnt = 0;

  always #5 clk = ~clk;

  platform_reader dut (
    .clk            (clk),
    .reset          (reset),
    .line_start     (line_start),
    .next_y         (next_y),
    .camera_pos     (camera_pos),
    .pixel_req      (pixel_req),
    .x              (x),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .platform_pixel (platform_pixel),
    .pixel_valid    (pixel_valid),
    .fetch_busy     (fetch_busy),
    .underrun       (underrun)
  );

  // RAM: data valid exactly one cycle after mem_rd, junk otherwise.
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? ram[mem_addr] : 16'hA5A5;
  end

  always @(posedge clk) begin
    if (mem_rd) begin
      if (rd_cnt != 0 && mem_addr != rd_last + 15'd1) seq_err++;
      if (rd_cnt == 0) rd_first = mem_addr;
      rd_last = mem_addr;
      rd_cnt++;
    end
    if (fetch_busy) busy_seen = 1'b1;
    if (underrun) ur_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_cnt = 0; seq_err = 0; busy_seen = 1'b0; ur_cnt = 0;
  endtask

  task automatic pulse_ls(input logic [8:0] y, input logic [9:0] cam);
    next_y = y; camera_pos = cam; line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic lookup(input logic [9:0] xc, output logic pix, output logic val);
    pixel_req = 1'b1; x = xc;
    step();
    pix = platform_pixel; val = pixel_valid;
    pixel_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fetch_busy && n < 100) begin step(); n++; end
    checks++;
    if (fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: fetch_busy=%b after %0d cycles, required 0", fetch_busy, n);
    end
  endtask

  task automatic test_reset();
    logic p, v;
    reset = 1'b1;
    step(); step();
    checks += 6;
    if (mem_rd !== 1'b0)         begin errors++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
    if (mem_addr !== 15'd0)      begin errors++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
    if (platform_pixel !== 1'b0) begin errors++; $display("FAIL rst_pixel: got %b want 0", platform_pixel); end
    if (pixel_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %b want 0", pixel_valid); end
    if (fetch_busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", fetch_busy); end
    if (underrun !== 1'b0)       begin errors++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    reset = 1'b0;
    step();
    lookup(10'd0, p, v);
    checks += 3;
    if (mem_rd !== 1'b0) begin errors++; $display("FAIL idle_mem_rd: got %b want 0", mem_rd); end
    if (p !== 1'b0)      begin errors++; $display("FAIL rst_lookup_pix: got %b want 0", p); end
    if (v !== 1'b1)      begin errors++; $display("FAIL rst_lookup_valid: got %b want 1", v); end
  endtask

  task automatic test_prefetch();
    logic p, v, e;
    clear_mon();
    pulse_ls(9'd150, 10'd0);
    checks += 3;
    if (fetch_busy !== 1'b1)   begin errors++; $display("FAIL pf_busy: got %b want 1", fetch_busy); end
    if (mem_rd !== 1'b1)       begin errors++; $display("FAIL pf_first_rd: got %b want 1", mem_rd); end
    if (mem_addr !== 15'd6000) begin errors++; $display("FAIL pf_first_addr: got %0d want 6000", mem_addr); end
    wait_idle();
    checks += 5;
    if (rd_cnt !== 40)            begin errors++; $display("FAIL pf_rd_count: got %0d want 40", rd_cnt); end
    if (rd_first !== 15'd6000)    begin errors++; $display("FAIL pf_addr_first: got %0d want 6000", rd_first); end
    if (rd_last !== 15'd6039)     begin errors++; $display("FAIL pf_addr_last: got %0d want 6039", rd_last); end
    if (seq_err !== 0)            begin errors++; $display("FAIL pf_addr_seq: got %0d gaps want 0", seq_err); end
    if (ur_cnt !== 0)             begin errors++; $display("FAIL pf_no_underrun: got %0d want 0", ur_cnt); end
    pulse_ls(9'd200, 10'd0);
    for (int i = 0; i < 640; i++) begin
      e = (i >= 48 && i <= 175);
      lookup(10'(i), p, v);
      checks += 2;
      if (p !== e)    begin errors++; $display("FAIL pf_pixel x=%0d: got %b want %b", i, p, e); end
      if (v !== 1'b1) begin errors++; $display("FAIL pf_valid x=%0d: got %b want 1", i, v); end
    end
    pixel_req = 1'b0; x = 10'd100;
    step();
    checks += 2;
    if (platform_pixel !== 1'b0) begin errors++; $display("FAIL noreq_pixel: got %b want 0", platform_pixel); end
    if (pixel_valid !== 1'b0)    begin errors++; $display("FAIL noreq_valid: got %b want 0", pixel_valid); end
    wait_idle();
  endtask

  task automatic test_scroll_wrap();
    logic p, v;
    int   xa [10] = '{40, 88, 39, 0, 100, 615, 87, 215, 216, 48};
    logic ea [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int   xb [4]  = '{328, 327, 455, 456};
    logic eb [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    pulse_ls(9'd150, 10'd0); wait_idle();
    pulse_ls(9'd200, 10'd600);
    for (int i = 0; i < 10; i++) begin
      lookup(10'(xa[i]), p, v);
      checks++;
      if (p !== ea[i]) begin errors++; $display("FAIL scroll600 x=%0d: got %b want %b", xa[i], p, ea[i]); end
    end
    wait_idle();
    pulse_ls(9'd150, 10'd0); wait_idle();
    pulse_ls(9'd200, 10'd1000);
    for (int i = 0; i < 4; i++) begin
      lookup(10'(xb[i]), p, v);
      checks++;
      if (p !== eb[i]) begin errors++; $display("FAIL scroll1000 x=%0d: got %b want %b", xb[i], p, eb[i]); end
    end
    wait_idle();
  endtask

  task automatic test_out_of_range();
    logic p, v;
    int   xs [4] = '{48, 100, 175, 0};
    pulse_ls(9'd150, 10'd0); wait_idle();
    pulse_ls(9'd150, 10'd0); wait_idle();
    clear_mon();
    pulse_ls(9'd480, 10'd0);
    checks += 2;
    if (fetch_busy !== 1'b0) begin errors++; $display("FAIL oor_busy: got %b want 0", fetch_busy); end
    if (mem_rd !== 1'b0)     begin errors++; $display("FAIL oor_mem_rd: got %b want 0", mem_rd); end
    lookup(10'd100, p, v);
    checks++;
    if (p !== 1'b1) begin errors++; $display("FAIL oor_front_kept: got %b want 1", p); end
    repeat (10) step();
    pulse_ls(9'd480, 10'd0);
    for (int i = 0; i < 4; i++) begin
      lookup(10'(xs[i]), p, v);
      checks++;
      if (p !== 1'b0) begin errors++; $display("FAIL oor_cleared x=%0d: got %b want 0", xs[i], p); end
    end
    checks += 2;
    if (rd_cnt !== 0)         begin errors++; $display("FAIL oor_rd_count: got %0d want 0", rd_cnt); end
    if (busy_seen !== 1'b0)   begin errors++; $display("FAIL oor_busy_seen: got %b want 0", busy_seen); end
  endtask

  task automatic test_underrun();
    logic p, v;
    int   xs [7] = '{0, 288, 303, 304, 319, 320, 639};
    logic es [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    pulse_ls(9'd151, 10'd0);
    repeat (19) step();
    pulse_ls(9'd200, 10'd0);
    checks += 4;
    if (underrun !== 1'b1)     begin errors++; $display("FAIL ur_pulse: got %b want 1", underrun); end
    if (mem_rd !== 1'b1)       begin errors++; $display("FAIL ur_restart_rd: got %b want 1", mem_rd); end
    if (mem_addr !== 15'd8000) begin errors++; $display("FAIL ur_restart_addr: got %0d want 8000", mem_addr); end
    if (fetch_busy !== 1'b1)   begin errors++; $display("FAIL ur_busy: got %b want 1", fetch_busy); end
    step();
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL ur_one_cycle: got %b want 0", underrun); end
    for (int i = 0; i < 7; i++) begin
      lookup(10'(xs[i]), p, v);
      checks++;
      if (p !== es[i]) begin errors++; $display("FAIL ur_partial x=%0d: got %b want %b", xs[i], p, es[i]); end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_fetch();
    logic p, v;
    int   n = 0;
    pulse_ls(9'd151, 10'd0); wait_idle();
    pulse_ls(9'd151, 10'd0);
    while (mem_addr != 15'd6051 && n < 60) begin step(); n++; end
    pixel_req = 1'b1; x = 10'd0;
    step();
    pixel_req = 1'b0;
    checks += 2;
    if (mem_addr !== 15'd6052)   begin errors++; $display("FAIL rmf_word12: got addr %0d want 6052", mem_addr); end
    if (platform_pixel !== 1'b1) begin errors++; $display("FAIL rmf_pre_pixel: got %b want 1", platform_pixel); end
    reset = 1'b1;
    #1;
    checks += 6;
    if (mem_rd !== 1'b0)         begin errors++; $display("FAIL rmf_mem_rd: got %b want 0", mem_rd); end
    if (mem_addr !== 15'd0)      begin errors++; $display("FAIL rmf_mem_addr: got %0d want 0", mem_addr); end
    if (fetch_busy !== 1'b0)     begin errors++; $display("FAIL rmf_busy: got %b want 0", fetch_busy); end
    if (platform_pixel !== 1'b0) begin errors++; $display("FAIL rmf_pixel: got %b want 0", platform_pixel); end
    if (pixel_valid !== 1'b0)    begin errors++; $display("FAIL rmf_valid: got %b want 0", pixel_valid); end
    if (underrun !== 1'b0)       begin errors++; $display("FAIL rmf_underrun: got %b want 0", underrun); end
    step(); step();
    reset = 1'b0;
    step();
    lookup(10'd0, p, v);
    checks++;
    if (p !== 1'b0) begin errors++; $display("FAIL rmf_after_x0: got %b want 0", p); end
    lookup(10'd639, p, v);
    checks += 2;
    if (p !== 1'b0)      begin errors++; $display("FAIL rmf_after_x639: got %b want 0", p); end
    if (mem_rd !== 1'b0) begin errors++; $display("FAIL rmf_idle_rd: got %b want 0", mem_rd); end
    pulse_ls(9'd200, 10'd0);
    lookup(10'd0, p, v);
    checks++;
    if (p !== 1'b0) begin errors++; $display("FAIL rmf_back_cleared: got %b want 0", p); end
    wait_idle();
    pulse_ls(9'd151, 10'd0); wait_idle();
    pulse_ls(9'd200, 10'd0);
    lookup(10'd0, p, v);
    checks++;
    if (p !== 1'b1) begin errors++; $display("FAIL rmf_refill_x0: got %b want 1", p); end
    lookup(10'd639, p, v);
    checks++;
    if (p !== 1'b1) begin errors++; $display("FAIL rmf_refill_x639: got %b want 1", p); end
    wait_idle();
  endtask

  task automatic test_simultaneous();
    logic p, v;
    pulse_ls(9'd150, 10'd0); wait_idle();
    pulse_ls(9'd200, 10'd0); wait_idle();
    next_y = 9'd200; camera_pos = 10'd600; line_start = 1'b1;
    pixel_req = 1'b1; x = 10'd100;
    step();
    line_start = 1'b0; pixel_req = 1'b0;
    checks += 2;
    if (platform_pixel !== 1'b1) begin errors++; $display("FAIL sim_pre_bank: got %b want 1", platform_pixel); end
    if (pixel_valid !== 1'b1)    begin errors++; $display("FAIL sim_valid: got %b want 1", pixel_valid); end
    lookup(10'd100, p, v);
    checks++;
    if (p !== 1'b0) begin errors++; $display("FAIL sim_post_bank: got %b want 0", p); end
    wait_idle();
    pulse_ls(9'd150, 10'd0); wait_idle();
    pulse_ls(9'd150, 10'd600); wait_idle();
    next_y = 9'd150; camera_pos = 10'd0; line_start = 1'b1;
    pixel_req = 1'b1; x = 10'd48;
    step();
    line_start = 1'b0; pixel_req = 1'b0;
    checks++;
    if (platform_pixel !== 1'b0) begin errors++; $display("FAIL sim_pre_scroll: got %b want 0", platform_pixel); end
    lookup(10'd48, p, v);
    checks++;
    if (p !== 1'b1) begin errors++; $display("FAIL sim_post_scroll: got %b want 1", p); end
    wait_idle();
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) ram[a] = 16'h0000;
    for (int w = 3; w <= 10; w++) ram[150*40 + w] = 16'hFFFF;
    for (int w = 0; w < 40; w++)  ram[151*40 + w] = 16'hFFFF;

    test_reset();
    test_prefetch();
    test_scroll_wrap();
    test_out_of_range();
    test_underrun();
    test_reset_mid_fetch();
    test_simultaneous();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_platform_reader
`default_nettype wire
